// File: rtl/posit_pkg.sv
// Shared types and constants for the posit encoder.
package posit_pkg;

  localparam int unsigned POSIT_N  = 32;
  localparam int unsigned POSIT_ES = 4;
  localparam int unsigned POSIT_SW = 10;
  localparam int unsigned POSIT_FW = 32;
  localparam int unsigned PW_MAX   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // NaR: sign bit alone.
  function automatic logic [PW_MAX-1:0] posit_nar(input int unsigned n);
    return PW_MAX'(1) << (n - 1);
  endfunction

  // Largest positive posit: all ones below the sign bit.
  function automatic logic [PW_MAX-1:0] posit_maxpos(input int unsigned n);
    return (PW_MAX'(1) << (n - 1)) - PW_MAX'(1);
  endfunction

  // Smallest positive posit.
  function automatic logic [PW_MAX-1:0] posit_minpos(input int unsigned n);
    if (n == 0) return '0;
    return PW_MAX'(1);
  endfunction

  // Largest representable |scale|: (n-2)*2^es.
  function automatic int posit_scale_lim(input int unsigned n, input int unsigned es);
    return int'((n - 2) << es);
  endfunction

endpackage

// File: rtl/posit_round_rne.sv
// Rounds a posit body, clamps carry/zero, and applies sign negation.
// POSIT_ENC_ROUND_EN selects round-to-nearest-even; otherwise truncation.
module posit_round_rne
  import posit_pkg::*;
#(
  parameter int unsigned N = POSIT_N
) (
  input  logic [N-2:0] body,
  input  logic         guard,
  input  logic         sticky,
  input  logic         sign,
  output logic [N-1:0] word_c
);

  localparam logic [N-1:0] MAXPOS_W = N'(posit_maxpos(N));
  localparam logic [N-1:0] MINPOS_W = N'(posit_minpos(N));

  logic         inc_c;
  logic [N-1:0] sum_c;
  logic [N-1:0] mag_c;

`ifdef POSIT_ENC_ROUND_EN
  assign inc_c = guard & (sticky | body[0]);
`else
  logic unused_rnd_c;
  assign inc_c        = 1'b0;
  assign unused_rnd_c = guard ^ sticky;
`endif

  // Increment, keep nonzero values off 0/NaR, then negate if needed.
  always_comb begin
    sum_c = {1'b0, body} + N'(inc_c);
    mag_c = sum_c;
    if (sum_c[N-1]) begin
      mag_c = MAXPOS_W;
    end else if (sum_c == '0) begin
      mag_c = MINPOS_W;
    end
    word_c = sign ? (~mag_c + N'(1)) : mag_c;
  end

endmodule

// File: rtl/posit_encoder.sv
// Packs sign/scale/fraction into an N-bit posit with saturation and rounding.
// Optional macro: POSIT_ENC_ROUND_EN (round-to-nearest-even; truncation if undefined).
module posit_encoder
  import posit_pkg::*;
#(
  parameter int unsigned N  = POSIT_N,
  parameter int unsigned ES = POSIT_ES,
  parameter int unsigned SW = POSIT_SW,
  parameter int unsigned FW = POSIT_FW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic                 in_zero,
  input  logic                 in_nar,
  input  logic signed [SW-1:0] in_scale,
  input  logic [FW-1:0]        in_frac,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_posit,
  output logic [15:0]          sat_cnt
);

  localparam int unsigned EW        = N + 1 + ES + FW;
  localparam int          SCALE_LIM = posit_scale_lim(N, ES);
  localparam logic [N-1:0] NAR_W    = N'(posit_nar(N));
  localparam logic [N-1:0] MAXPOS_W = N'(posit_maxpos(N));
  localparam logic [N-1:0] MINPOS_W = N'(posit_minpos(N));

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic                  zero_q, zero_d;
  logic                  nar_q, nar_d;
  logic signed [SW-1:0]  scale_q, scale_d;
  logic [FW-1:0]         frac_q, frac_d;
  logic [N-2:0]          body_q, body_d;
  logic                  guard_q, guard_d;
  logic                  sticky_q, sticky_d;
  logic [15:0]           sat_cnt_q, sat_cnt_d;
  logic [N-1:0]          out_posit_q, out_posit_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;

  logic signed [SW-1:0]  k_c;
  logic [ES-1:0]         e_c;
  logic                  fill_c;
  int                    nfill_c;
  logic [7:0]            sh_c;
  logic [EW-1:0]         ext_raw_c;
  logic [EW-1:0]         ext_sh_c;
  logic [N-2:0]          body_c;
  logic                  guard_c;
  logic                  sticky_c;
  logic                  sat_hi_c;
  logic                  sat_lo_c;
  logic [N-1:0]          rnd_word_c;

  // Regime/exponent/fraction string built from the captured scale.
  always_comb begin
    k_c       = scale_q >>> ES;
    e_c       = scale_q[ES-1:0];
    fill_c    = ~k_c[SW-1];
    nfill_c   = fill_c ? (int'(k_c) + 1) : -int'(k_c);
    sh_c      = 8'(int'(N) - nfill_c);
    ext_raw_c = {{N{fill_c}}, ~fill_c, e_c, frac_q};
    ext_sh_c  = ext_raw_c << sh_c;
    body_c    = ext_sh_c[EW-1 -: N-1];
    guard_c   = ext_sh_c[EW-N];
    sticky_c  = |ext_sh_c[EW-N-1:0];
    sat_hi_c  = int'(scale_q) > SCALE_LIM;
    sat_lo_c  = int'(scale_q) < -SCALE_LIM;
  end

  posit_round_rne #(.N(N)) u_round (
    .body   (body_q),
    .guard  (guard_q),
    .sticky (sticky_q),
    .sign   (sign_q),
    .word_c (rnd_word_c)
  );

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    zero_d      = zero_q;
    nar_d       = nar_q;
    scale_d     = scale_q;
    frac_d      = frac_q;
    body_d      = body_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    sat_cnt_d   = sat_cnt_q;
    out_posit_d = out_posit_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d  = in_sign;
          zero_d  = in_zero;
          nar_d   = in_nar;
          scale_d = in_scale;
          frac_d  = in_frac;
          state_d = ST_PACK;
        end
      end
      ST_PACK: begin
        body_d   = body_c;
        guard_d  = guard_c;
        sticky_d = sticky_c;
        if (sat_hi_c || sat_lo_c) begin
          body_d   = sat_hi_c ? MAXPOS_W[N-2:0] : MINPOS_W[N-2:0];
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          if (!nar_q && !zero_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
          end
        end
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (nar_q) begin
          out_posit_d = NAR_W;
        end else if (zero_q) begin
          out_posit_d = '0;
        end else begin
          out_posit_d = rnd_word_c;
        end
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_OUT);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      nar_q       <= 1'b0;
      scale_q     <= '0;
      frac_q      <= '0;
      body_q      <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      sat_cnt_q   <= '0;
      out_posit_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      nar_q       <= nar_d;
      scale_q     <= scale_d;
      frac_q      <= frac_d;
      body_q      <= body_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      sat_cnt_q   <= sat_cnt_d;
      out_posit_q <= out_posit_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_posit = out_posit_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
